sgpio_tx: RTL

- SGPIO initiator for the status CPLD. Generates SGPIO_CK, SGPIO_LD and SGPIO_DATA toward a downstream drive-LED target (backplane or peer CPLD).
- Serialises a per-drive 3-bit LED vector (activity, locate, fault), frame after frame, and captures the returned SGPIO_DIN stream into a per-drive status vector.
- Runs on SYSCLK. The I2C register file supplies led_data and enable, and reads rx_status.

---
 rtl/sgpio_tx.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sgpio_tx.sv
// rtl/sgpio_tx.sv - SGPIO initiator: serialises per-drive LED bits and captures the returned status stream
module sgpio_tx #(
    parameter int HDD_NUM = 36,
    parameter int CLK_DIV = 125
) (
    input  logic                   SYSCLK,
    input  logic                   RESET_N,
    input  logic                   enable,
    input  logic [HDD_NUM*3-1:0]   led_data,
    input  logic                   SGPIO_DIN,
    output logic                   SGPIO_CK,
    output logic                   SGPIO_LD,
    output logic                   SGPIO_DATA,
    output logic [HDD_NUM*3-1:0]   rx_status,
    output logic                   frame_done,
    output logic                   busy
);
    localparam int NBITS = HDD_NUM * 3;
    localparam int CW    = (NBITS > 1) ? $clog2(NBITS) : 1;

    localparam logic [9:0]    DIV_LAST = 10'(CLK_DIV - 1);
    localparam logic [9:0]    DIV_ONE  = 10'd1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);
    localparam logic [CW-1:0] CNT_PEN  = CW'(NBITS - 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t             state_q;
    logic [9:0]         div_q;
    logic [9:0]         div_d;
    logic               ck_q;
    logic               ld_q;
    logic               data_q;
    logic [CW-1:0]      cnt_q;
    logic [NBITS-1:0]   sh_q;
    logic [NBITS-1:0]   rx_q;
    logic [NBITS-1:0]   rx_status_q;
    logic               frame_done_q;
    logic               din_meta_q;
    logic               din_sync_q;

    logic               div_tc;
    logic               fall_ev;
    logic               rise_ev;

    // The divider only runs outside IDLE, so every frame starts on a clean CK phase.
    always_comb begin
        div_tc  = (state_q != IDLE) && (div_q == DIV_LAST);
        fall_ev = div_tc && ck_q;
        rise_ev = div_tc && !ck_q;
        div_d   = div_tc ? '0 : (div_q + DIV_ONE);
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            div_q        <= '0;
            ck_q         <= 1'b0;
            ld_q         <= 1'b0;
            data_q       <= 1'b0;
            cnt_q        <= '0;
            sh_q         <= '0;
            rx_q         <= '0;
            rx_status_q  <= '0;
            frame_done_q <= 1'b0;
            din_meta_q   <= 1'b0;
            din_sync_q   <= 1'b0;
        end else begin
            din_meta_q   <= SGPIO_DIN;
            din_sync_q   <= din_meta_q;
            frame_done_q <= 1'b0;

            if (state_q != IDLE) begin
                div_q <= div_d;
                if (div_tc) begin
                    ck_q <= ~ck_q;
                end
            end

            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= SYNC;
                        ld_q    <= 1'b1;
                        data_q  <= 1'b0;
                        div_q   <= '0;
                        ck_q    <= 1'b0;
                    end
                end

                SYNC: begin
                    if (fall_ev) begin
                        sh_q    <= led_data;
                        data_q  <= led_data[0];
                        ld_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (rise_ev) begin
                        rx_q[cnt_q] <= din_sync_q;
                    end
                    if (fall_ev) begin
                        if (cnt_q != CNT_LAST) begin
                            cnt_q  <= cnt_q + CNT_ONE;
                            sh_q   <= sh_q >> 1;
                            data_q <= sh_q[1];
                            ld_q   <= (cnt_q == CNT_PEN);
                        end else begin
                            // Frame boundary: publish the whole received frame at once.
                            rx_status_q  <= rx_q;
                            frame_done_q <= 1'b1;
                            cnt_q        <= '0;
                            if (enable) begin
                                sh_q   <= led_data;
                                data_q <= led_data[0];
                                ld_q   <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                                ck_q    <= 1'b0;
                                ld_q    <= 1'b0;
                                data_q  <= 1'b0;
                            end
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign SGPIO_CK   = ck_q;
    assign SGPIO_LD   = ld_q;
    assign SGPIO_DATA = data_q;
    assign rx_status  = rx_status_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);

endmodule
